// File: rtl/cpp_internal_double_to_bool_sched.sv
// cpp_internal_double_to_bool_sched: round-robin shared double-to-bool hysteresis comparator
module cpp_internal_double_to_bool_sched #(
  parameter int          N_CH      = 4,
  parameter logic [63:0] THRESH_HI = 64'h3F847AE147AE147B,
  parameter logic [63:0] THRESH_LO = 64'h3F847AE147AE147B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req_i,
  input  logic [64*N_CH-1:0] data_i,
  output logic [N_CH-1:0]   ack_o,
  output logic [N_CH-1:0]   out_o,
  output logic [N_CH-1:0]   update_out_o,
  output logic              busy_o
);
  localparam int GW = N_CH > 1 ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t            state_q, state_d;
  logic [GW-1:0]     rr_q, rr_d, g_q, g_d, grant;
  logic              found, gt_hi, le_lo;
  logic [63:0]       x_q, x_d;
  logic [N_CH-1:0]   ack_q, ack_d, out_q, out_d, upd_q, upd_d;
  // thresholds are positive, so magnitude bits compare as unsigned integers
  function automatic logic gt(input logic [63:0] x, input logic [62:0] t);
    return !x[63] && !(x[62:52] == 11'h7FF && x[51:0] != '0) && (x[62:0] > t);
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      x_q     <= '0;
      ack_q   <= '0;
      out_q   <= '0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      x_q     <= x_d;
      ack_q   <= ack_d;
      out_q   <= out_d;
      upd_q   <= upd_d;
    end
  // lowest offset from rr_q wins: the descending loop lets it overwrite later
  always_comb begin
    found = 1'b0;
    grant = rr_q;
    for (int i = N_CH - 1; i >= 0; i--)
      if (req_i[(int'(rr_q) + i) % N_CH]) begin
        found = 1'b1;
        grant = GW'((int'(rr_q) + i) % N_CH);
      end
  end
  always_comb
    state_d = state_q == IDLE ? (found ? CMP : IDLE) : state_q == CMP ? DONE : IDLE;
  always_comb begin
    gt_hi = gt(x_q, THRESH_HI[62:0]);
    le_lo = !gt(x_q, THRESH_LO[62:0]);
    g_d   = (state_q == IDLE && found) ? grant : g_q;
    x_d   = (state_q == IDLE && found) ? data_i[64*grant +: 64] : x_q;
    rr_d  = state_q == DONE ? (g_q == GW'(N_CH - 1) ? '0 : GW'(int'(g_q) + 1)) : rr_q;
    ack_d = '0;
    out_d = out_q;
    upd_d = upd_q;
    // results land on the CMP->DONE edge so ack/out/update_out are visible throughout DONE
    if (state_q == CMP) begin
      out_d[g_q] = out_q[g_q] ? !le_lo : gt_hi;
      upd_d[g_q] = !upd_q[g_q];
      ack_d[g_q] = 1'b1;
    end
  end
  always_comb begin
    busy_o       = state_q != IDLE;
    ack_o        = ack_q;
    out_o        = out_q;
    update_out_o = upd_q;
  end
endmodule

// File: tb/tb_cpp_internal_double_to_bool_sched.sv
// tb_cpp_internal_double_to_bool_sched: directed scoreboard bench with default and hysteresis instances
module tb_cpp_internal_double_to_bool_sched;
  logic         clk, rst_n;
  logic [3:0]   req_a, ack_a, out_a, upd_a, req_b, ack_b, out_b, upd_b;
  logic [255:0] data_a, data_b;
  logic         busy_a, busy_b;
  int           passed = 0, total = 0;
  typedef struct {logic [3:0] ack, o, u;} exp_t;
  exp_t         sb[$];
  logic [3:0]   eo_a = '0, eu_a = '0, eo_b = '0, eu_b = '0;

  cpp_internal_double_to_bool_sched u_a (
    .clk(clk), .rst_n(rst_n), .req_i(req_a), .data_i(data_a),
    .ack_o(ack_a), .out_o(out_a), .update_out_o(upd_a), .busy_o(busy_a));
  cpp_internal_double_to_bool_sched #(
    .N_CH(4), .THRESH_HI(64'h3FF0000000000000), .THRESH_LO(64'h3FE0000000000000)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .data_i(data_b),
    .ack_o(ack_b), .out_o(out_b), .update_out_o(upd_b), .busy_o(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send(input bit b, input int ch, input logic [63:0] v, input logic eo, input string tag);
    exp_t e;
    int   n;
    if (b) begin
      eo_b[ch] = eo; eu_b[ch] = ~eu_b[ch];
      e = '{ack: 4'(1 << ch), o: eo_b, u: eu_b};
    end else begin
      eo_a[ch] = eo; eu_a[ch] = ~eu_a[ch];
      e = '{ack: 4'(1 << ch), o: eo_a, u: eu_a};
    end
    sb.push_back(e);
    @(negedge clk);
    if (b) begin req_b[ch] = 1'b1; data_b[64*ch +: 64] = v; end
    else begin req_a[ch] = 1'b1; data_a[64*ch +: 64] = v; end
    n = 0;
    do begin @(negedge clk); n++; end while ((b ? ack_b : ack_a) == '0 && n < 8);
    e = sb.pop_front();
    chk({tag, "_lat"}, 64'(n), 64'd2);
    chk({tag, "_ack"}, 64'(b ? ack_b : ack_a), 64'(e.ack));
    chk({tag, "_out"}, 64'(b ? out_b : out_a), 64'(e.o));
    chk({tag, "_upd"}, 64'(b ? upd_b : upd_a), 64'(e.u));
    if (b) req_b[ch] = 1'b0; else req_a[ch] = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   n, last;
    rst_n = 1'b0; req_a = '0; req_b = '0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", 64'({out_a, upd_a, ack_a}), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_outs", 64'({busy_a, out_a, upd_a, ack_a, busy_b, out_b, upd_b, ack_b}), 64'd0);
    end
    // single channel, default thresholds (0.01 itself is not above 0.01)
    send(0, 0, 64'h3F947AE147AE147B, 1'b1, "c0_p02");
    send(0, 0, 64'h3F847AE147AE147B, 1'b0, "c0_p01");
    send(0, 0, 64'hC014000000000000, 1'b0, "c0_m5");
    // hysteresis band [0.5, 1.0]
    send(1, 1, 64'h3FE6666666666666, 1'b0, "hy_07a");
    send(1, 1, 64'h3FF8000000000000, 1'b1, "hy_15");
    send(1, 1, 64'h3FE6666666666666, 1'b1, "hy_07b");
    send(1, 1, 64'h3FE0000000000000, 1'b0, "hy_05");
    // special values and the ulp just above threshold
    send(0, 3, 64'h7FF0000000000000, 1'b1, "sp_inf");
    send(0, 3, 64'h7FF8000000000000, 1'b0, "sp_nan");
    send(0, 3, 64'h3F847AE147AE147C, 1'b1, "sp_ulp");
    send(0, 3, 64'h8000000000000000, 1'b0, "sp_mzero");
    send(0, 2, 64'hFFF0000000000000, 1'b0, "sp_minf");
    // reset during CMP for ch2
    @(negedge clk);
    req_a[2] = 1'b1; data_a[128 +: 64] = 64'h3F947AE147AE147B;
    @(posedge clk); #1;
    chk("mid_busy", 64'(busy_a), 64'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_ack", 64'(ack_a), 64'd0);
    chk("mid_rst_out", 64'({out_a, upd_a, busy_a}), 64'd0);
    eo_a = '0; eu_a = '0;
    repeat (2) @(negedge clk);
    chk("mid_hold_ack", 64'(ack_a), 64'd0);
    eo_a[2] = 1'b1; eu_a[2] = 1'b1;
    sb.push_back('{ack: 4'b0100, o: eo_a, u: eu_a});
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ack_a == '0 && n < 8);
    e = sb.pop_front();
    chk("post_rst_lat", 64'(n), 64'd2);
    chk("post_rst_ack", 64'(ack_a), 64'(e.ack));
    chk("post_rst_out", 64'(out_a), 64'(e.o));
    chk("post_rst_upd", 64'(upd_a), 64'(e.u));
    req_a = '0;
    // round robin with all requests held from reset
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 4'hF;
    for (int i = 0; i < 4; i++) data_a[64*i +: 64] = 64'h3F947AE147AE147B;
    sb.push_back('{ack: 4'b0001, o: 4'b0001, u: 4'b0001});
    sb.push_back('{ack: 4'b0010, o: 4'b0011, u: 4'b0011});
    sb.push_back('{ack: 4'b0100, o: 4'b0111, u: 4'b0111});
    sb.push_back('{ack: 4'b1000, o: 4'b1111, u: 4'b1111});
    sb.push_back('{ack: 4'b0001, o: 4'b1111, u: 4'b1110});
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; last = 0;
    for (int k = 0; k < 5; k++) begin
      do begin @(negedge clk); n++; end while (ack_a == '0 && n < last + 8);
      e = sb.pop_front();
      chk("rr_gap", 64'(n - last), k == 0 ? 64'd2 : 64'd3);
      chk("rr_ack", 64'(ack_a), 64'(e.ack));
      chk("rr_out", 64'(out_a), 64'(e.o));
      chk("rr_upd", 64'(upd_a), 64'(e.u));
      last = n;
    end
    req_a = '0;
    repeat (2) @(negedge clk);
    chk("end_idle", 64'({busy_a, ack_a}), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cpp_internal_double_to_bool_sched.md
# cpp_internal_double_to_bool_sched

Round-robin scheduler that shares one IEEE-754 double-to-bool hysteresis comparator among N_CH requesting channels. Each channel presents a 64-bit double under a req/ack handshake. The scheduler serialises the requests, compares each value against a high and a low threshold, and keeps one hysteresis state bit per channel. It sits between multiple analog-to-digital signal taps and the boolean event logic, replacing per-channel converter instances with one clocked, shared compare path.

## Interface
- N_CH, 4: number of requesting channels, 2..16.
- THRESH_HI, 64'h3F847AE147AE147B (0.01): rising threshold bit pattern; must be positive and finite.
- THRESH_LO, 64'h3F847AE147AE147B (0.01): falling threshold bit pattern; positive, finite, THRESH_LO <= THRESH_HI.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_CH  per-channel request; held high with data stable until ack.
- data  in  64*N_CH  channel i double at bits [64*i+63 : 64*i].
- ack  out  N_CH  one-cycle completion pulse to the served channel.
- out  out  N_CH  per-channel boolean state, registered.
- update_out  out  N_CH  per-channel toggle, inverts once for each completed evaluation.
- busy  out  1  high whenever state != IDLE.

## Operation
- Reset value of every output and register: out=0, update_out=0, ack=0, busy=0, state=IDLE, rr_ptr=0, latched data=0.
- States:
  - IDLE: if any req bit is set, grant the first set bit at or after rr_ptr, searching upward and wrapping modulo N_CH. Latch data[g] and g, then go to CMP. Otherwise stay in IDLE.
  - CMP: compute gt_hi = (x > THRESH_HI) and le_lo = (x <= THRESH_LO). Register both flags and go to DONE.
  - DONE: update the hysteresis bit for channel g:
    - If out[g]=0 and gt_hi, set out[g]=1.
    - If out[g]=1 and le_lo, set out[g]=0.
    - Otherwise hold out[g].
  - DONE also toggles update_out[g], pulses ack[g] for this cycle only, sets rr_ptr=(g+1) mod N_CH, and returns to IDLE.
- Compare arithmetic (thresholds positive; no floating-point unit):
  - x > T exactly when sign(x)=0, x is not NaN, and x[62:0] > T[62:0] as an unsigned integer.
  - x <= T is the logical complement of x > T.
  - Consequences: negative values, -0.0, +0.0 and all NaNs count as <= T. +Inf counts as > T.
- Only channel g changes its out or update_out bit in a given evaluation. Other channels hold their bits.
- The value is latched in IDLE. A requester changing data or dropping req after the grant does not affect the result. Dropping req before ack is a protocol violation; the block still completes and issues ack.
- If req[g] is still high in the cycle after ack, it counts as a new request.
- With THRESH_LO = THRESH_HI, behaviour is out[g] = (x > THRESH_HI) after each update.

## Timing
- Grant latency: req sampled high at edge k while in IDLE gives CMP at k+1 and DONE at k+2.
- ack, out and update_out change together and are visible during the DONE cycle.
- Throughput is one evaluation per 3 cycles; the block always passes through IDLE after DONE.
- Worst-case wait for a continuously requesting channel is 3*N_CH cycles.
- Simultaneous requests are served in round-robin order starting from rr_ptr. A newly arriving req is sampled only in IDLE.
- Reset asserted mid-operation takes effect immediately, asynchronously. In-flight work is discarded: no ack and no out change. A requester still holding req is served after rst_n deasserts, with rr_ptr restarted at 0.
- rst_n deassertion is synchronous to clk; the first grant is possible at the first edge after release.

## Test plan
- Reset and idle: hold rst_n=0, then release with req=0 -> all outputs stay 0 and busy=0 indefinitely.
- Single channel, defaults: ch0 sends 0.02, then 0.01, then -5.0.
  - out[0] goes 1, then 0, then 0.
  - update_out[0] toggles three times.
  - Each ack[0] arrives 2 cycles after its req is sampled.
- Hysteresis: THRESH_HI=1.0 and THRESH_LO=0.5; ch1 sends 0.7, 1.5, 0.7, 0.5.
  - out[1] goes 0, 1, 1, 0.
- Round robin: N_CH=4, all req held high from reset -> ack order 0,1,2,3,0 with acks 3 cycles apart.
- Special values:
  - +Inf gives out=1.
  - NaN (7FF8000000000000) gives out=0 from state 1.
  - -0.0 gives out=0.
  - update_out toggles for every evaluation.
- Reset mid-operation: assert rst_n=0 during CMP for ch2.
  - No ack[2] is issued.
  - out and update_out return to 0.
  - With req[2] still high, ack[2] arrives 2 cycles after the first post-reset edge.
